// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
    parameter int unsigned clks_per_bit = 217,
    parameter int unsigned stop_bits    = 1,
    parameter bit          parity_odd   = 1'b0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int unsigned CntW = $clog2(clks_per_bit);
    localparam logic [CntW-1:0] CntMax = CntW'(clks_per_bit - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic [7:0]      shift_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic            stop_q;
    logic            done_q;

    logic bit_end, stop_last, frame_end, load, accept, parity_bit;

    assign bit_end   = (cnt_q == CntMax);
    assign stop_last = (stop_bits == 32'd1) || stop_q;
    assign frame_end = (state_q == StStop) && bit_end && stop_last;
    // The holding register can only be full here if it was filled on an earlier edge,
    // so accept and load are mutually exclusive.
    assign load      = hold_full_q && ((state_q == StIdle) || frame_end);
    assign accept    = i_tx_dv && !hold_full_q;

`ifdef UART_TX_PARITY_EN
    assign parity_bit = (^shift_q) ^ parity_odd;
`else
    assign parity_bit = 1'b1;
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (load) state_d = StStart;
            StStart:  if (bit_end) state_d = StData;
            StData: begin
                if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (frame_end) state_d = load ? StStart : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (accept) begin
                hold_q      <= i_tx_byte;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            if (load) shift_q <= hold_q;
            if ((state_q == StIdle) || bit_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if ((state_q == StData) && bit_end) idx_q <= idx_q + 3'd1;
            if ((state_q == StStop) && bit_end) stop_q <= !stop_last;
        end
    end

    always_comb begin
        o_tx_ready  = !hold_full_q;
        o_tx_done   = done_q;
        o_tx_active = (state_q != StIdle);
        o_tx_serial = 1'b1;
        unique case (state_q)
            StStart:  o_tx_serial = 1'b0;
            StData:   o_tx_serial = shift_q[idx_q];
            StParity: o_tx_serial = parity_bit;
            default:  o_tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, queueing, drop, reset abort, two stop bits,
// parity (when UART_TX_PARITY_EN is defined) and a bench-side receiver at 217 clocks/bit.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int CPB  = 4;
    localparam int LCPB = 217;
    localparam int NB1  = 10 + PAR;
    localparam int NB2  = 11 + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dv, dv2, dv3;
    logic [7:0] byte_in, byte2, byte3;
    logic       ready, serial, active, done;
    logic       ready2, serial2, active2, done2;
    logic       ready3, serial3, active3, done3;

    int total = 0;
    int bad   = 0;

    logic [7:0] lb [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};

    uart_tx #(.clks_per_bit(CPB), .stop_bits(1), .parity_odd(1'b0)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_tx_dv(dv), .i_tx_byte(byte_in),
        .o_tx_ready(ready), .o_tx_serial(serial), .o_tx_active(active), .o_tx_done(done)
    );

    uart_tx #(.clks_per_bit(CPB), .stop_bits(2), .parity_odd(1'b1)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_tx_dv(dv2), .i_tx_byte(byte2),
        .o_tx_ready(ready2), .o_tx_serial(serial2), .o_tx_active(active2), .o_tx_done(done2)
    );

    uart_tx #(.clks_per_bit(LCPB), .stop_bits(1), .parity_odd(1'b0)) u_dut3 (
        .i_clock(clk), .i_reset(rst), .i_tx_dv(dv3), .i_tx_byte(byte3),
        .o_tx_ready(ready3), .o_tx_serial(serial3), .o_tx_active(active3), .o_tx_done(done3)
    );

    // Expected line level for bit slot bi of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int bi, input logic odd);
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (PAR == 1 && bi == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    // Called on the negedge where the start bit is first visible; returns on the
    // negedge after the final stop cycle.
    task automatic check_frame(input logic [7:0] b, input logic prev_done, input logic q_en,
                               input logic [7:0] q_byte, input logic junk_en);
        int errs = 0;
        int act_errs = 0;
        for (int k = 0; k < NB1 * CPB; k++) begin
            logic eb;
            eb = exp_bit(b, k / CPB, 1'b0);
            if (serial !== eb) errs++;
            if (active !== 1'b1) act_errs++;
            if (k == 0) begin
                total++;
                if (done !== prev_done) begin
                    bad++;
                    $display("FAIL frame_start_done byte=%h got=%b exp=%b", b, done, prev_done);
                end
            end else if (done !== 1'b0) begin
                act_errs++;
            end
            if (k == 2) byte_in = ~b;
            if (q_en) begin
                if (k == 8) begin
                    dv = 1'b1;
                    byte_in = q_byte;
                end
                if (k == 9) begin
                    total++;
                    if (ready !== 1'b0) begin
                        bad++;
                        $display("FAIL queued_ready got=%b exp=0", ready);
                    end
                    dv = junk_en;
                    if (junk_en) byte_in = 8'h33;
                end
                if (k == 10) dv = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL frame_bits byte=%h bad_cycles=%0d exp=0", b, errs);
        end
        total++;
        if (act_errs != 0) begin
            bad++;
            $display("FAIL frame_active byte=%h bad_cycles=%0d exp=0", b, act_errs);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL frame_done byte=%h got=%b exp=1", b, done);
        end
    endtask

    task automatic start_main(input logic [7:0] b);
        dv = 1'b1;
        byte_in = b;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || serial !== 1'b1) begin
            bad++;
            $display("FAIL accept_edge ready=%b serial=%b exp ready=0 serial=1", ready, serial);
        end
        dv = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv = 1'b0; dv2 = 1'b0; dv3 = 1'b0;
        byte_in = 8'h00; byte2 = 8'h00; byte3 = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (serial !== 1'b1) begin bad++; $display("FAIL reset_serial got=%b exp=1", serial); end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++;
        if ({ready2, serial2, active2, done2, ready3, serial3, active3, done3} !== 8'b1100_1100) begin
            bad++;
            $display("FAIL reset_others got=%b exp=11001100",
                     {ready2, serial2, active2, done2, ready3, serial3, active3, done3});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [7:0] b);
        start_main(b);
        check_frame(b, 1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (active !== 1'b0 || serial !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL after_frame active=%b serial=%b ready=%b exp 0 1 1", active, serial, ready);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        start_main(8'h01);
        check_frame(8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        check_frame(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) errs++;
            @(negedge clk);
        end
        total++;
        if (errs != 0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL dropped_byte_idle bad_cycles=%0d ready=%b exp 0 1", errs, ready);
        end
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        start_main(8'h00);
        repeat (8) @(negedge clk);
        dv = 1'b1;
        byte_in = 8'h5A;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || serial !== 1'b0) begin
            bad++;
            $display("FAIL mid_queue ready=%b serial=%b exp 0 0", ready, serial);
        end
        dv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({serial, ready, active, done} !== 4'b1100) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=1100", {serial, ready, active, done});
        end
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL after_reset_quiet bad_cycles=%0d exp=0", errs);
        end
    endtask

    task automatic test_stop2();
        int errs = 0;
        int act_errs = 0;
        dv2 = 1'b1;
        byte2 = 8'h80;
        @(negedge clk);
        dv2 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NB2 * CPB; k++) begin
            if (serial2 !== exp_bit(8'h80, k / CPB, 1'b1)) errs++;
            if (active2 !== 1'b1 || done2 !== 1'b0) act_errs++;
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL stop2_bits bad_cycles=%0d exp=0", errs); end
        total++;
        if (act_errs != 0) begin bad++; $display("FAIL stop2_active bad_cycles=%0d exp=0", act_errs); end
        total++;
        if (done2 !== 1'b1 || active2 !== 1'b0) begin
            bad++;
            $display("FAIL stop2_end done=%b active=%b exp 1 0", done2, active2);
        end
    endtask

    task automatic lb_send();
        for (int i = 0; i < 4; i++) begin
            int w = 0;
            while (ready3 !== 1'b1 && w < 5000) begin
                @(negedge clk);
                w++;
            end
            dv3 = 1'b1;
            byte3 = lb[i];
            @(negedge clk);
            dv3 = 1'b0;
        end
    endtask

    task automatic lb_recv();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            logic       st;
            int         w;
            w = 0;
            while (serial3 !== 1'b0 && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 5000) begin
                total++;
                bad++;
                $display("FAIL loopback_timeout byte_index=%0d exp=start_bit", i);
                return;
            end
            repeat (LCPB / 2) @(negedge clk);
            st = serial3;
            for (int j = 0; j < 8; j++) begin
                repeat (LCPB) @(negedge clk);
                got[j] = serial3;
            end
            repeat (LCPB * (1 + PAR)) @(negedge clk);
            total++;
            if (got !== lb[i] || st !== 1'b0 || serial3 !== 1'b1) begin
                bad++;
                $display("FAIL loopback byte=%h start=%b stop=%b exp byte=%h start=0 stop=1",
                         got, st, serial3, lb[i]);
            end
        end
    endtask

    task automatic test_loopback();
        fork
            lb_send();
            lb_recv();
        join
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_single(8'h07);
        test_reset_mid();
        test_stop2();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises 8-bit bytes onto a single line: start bit, 8 data bits LSB first, optional parity bit, then stop bit(s). It pairs with the team's uart_rx at the same baud rate and shares its clock domain. A one-entry holding register lets the host queue the next byte while the current frame shifts out, so back-to-back frames have no idle gap.

Parameters:
clks_per_bit, 217, clock cycles per serial bit (25 MHz / 115200); legal values are 2 or more.
stop_bits, 1, number of stop bits; legal values are 1 or 2.
parity_odd, 0, used only with UART_TX_PARITY_EN. 0 selects even parity, 1 selects odd parity.

Ports:
i_clock  input  1  system clock; all logic is on the rising edge.
i_reset  input  1  synchronous reset, active-high.
i_tx_dv  input  1  byte valid; sampled only when o_tx_ready=1.
i_tx_byte  input  8  byte to send; captured in the same cycle as the accept.
o_tx_ready  output  1  holding register is empty and can accept a byte.
o_tx_serial  output  1  serial line; idles high.
o_tx_active  output  1  high from the first start-bit cycle through the last stop-bit cycle.
o_tx_done  output  1  one-cycle pulse when a frame's final stop bit completes.

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset is synchronous and active-high.
- Reset values: o_tx_serial=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0. Holding register is empty, state is IDLE, bit counter and index are 0.
- Reset mid-frame: at the reset edge the frame is aborted, the line returns to 1, any queued byte is discarded and no o_tx_done pulse is issued.
- Accept: at edge E0, if i_tx_dv=1 and o_tx_ready=1, i_tx_byte is written into the holding register and o_tx_ready drops. If i_tx_dv=1 while o_tx_ready=0, the request is ignored and no data changes.
- Load: the shifter takes the byte from the holding register either in IDLE or at the last cycle of the final stop bit. On that edge, state becomes START, o_tx_serial becomes 0 and o_tx_ready rises. Latency from the accept edge E0 to the line going low is 1 cycle when idle (it goes low at E1).
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START if the holding register is full, else IDLE).
- Bit timing: every bit, including each stop bit, holds o_tx_serial for exactly clks_per_bit cycles. A cycle counter of width $clog2(clks_per_bit) counts 0..clks_per_bit-1, and the bit ends when the count equals clks_per_bit-1.
- DATA state: sends i_tx_byte[0] first and [7] last. A 3-bit index wraps 7->0 as the state exits to PARITY or STOP.
- STOP state: o_tx_serial=1 for stop_bits*clks_per_bit cycles.
- o_tx_done: asserted for exactly one cycle, on the cycle after the final stop-bit cycle, coincident with the first START cycle of any queued frame or with IDLE.
- Back-to-back frames: a byte queued before the final stop cycle ends starts with no idle gap.
- Simultaneous events: a new accept and a load cannot happen on the same edge, because o_tx_ready is 0 while the register is full.
- o_tx_active: high in START, DATA, PARITY and STOP; low in IDLE.
- Frame length: 10 bits with stop_bits=1, 11 bits with stop_bits=2.
- The byte is latched at load, so later changes on i_tx_byte do not corrupt a frame in flight.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA and lasts clks_per_bit cycles. The bit sent is the XOR of the 8 data bits, XOR parity_odd. Frame length grows by one bit.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP, and parity_odd has no effect.

Test Plan:
- clks_per_bit=4, idle, send 8'hA5 -> line reads low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. o_tx_done pulses once, 40 cycles after the line goes low, and o_tx_active is high for exactly 40 cycles.
- Send 8'h01 and queue 8'hFF while 8'h01 is in DATA -> the stop bit of frame 1 is followed immediately by the start of frame 2 with no gap. Two o_tx_done pulses occur exactly 40 cycles apart.
- While o_tx_ready=0, drive i_tx_dv=1 with 8'h33 -> the byte is dropped; only the previously queued bytes are sent.
- Assert i_reset during DATA of 8'h00 with a byte queued -> line is 1 on the next edge, o_tx_ready=1, no o_tx_done, and nothing further is transmitted.
- stop_bits=2, send 8'h80 -> the high stop period is 8 cycles and the frame is 44 cycles.
- UART_TX_PARITY_EN with parity_odd=0, send 8'h07 -> parity bit is 1 and the frame is 44 cycles. With parity_odd=1 the parity bit is 0.
- Loopback into uart_rx at clks_per_bit=217, sending 8'h00, 8'h55, 8'hAA, 8'hFF -> uart_rx outputs the identical bytes in order.
